// File: rtl/pixel_packer_pkg.sv
// pixel_packer_pkg: shared pixel/word types, packing phases and grey-to-RGB expansion
package pixel_packer_pkg;
    typedef logic [23:0] pixel24_t;
    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [31:0] data;
    } axis_word_t;
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;
    function automatic pixel24_t expand(input logic [7:0] s);
        return {s, s, s};
    endfunction
endpackage

// File: rtl/pixel_packer_if.sv
// pixel_packer_if: AXI4-Stream word output of the pixel packer
interface pixel_packer_if;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tuser;
    logic        out_tlast;
    modport master(output out_tdata, out_tvalid, out_tuser, out_tlast, input out_tready);
    modport slave(input out_tdata, out_tvalid, out_tuser, out_tlast, output out_tready);
endinterface

// File: rtl/pixel_packer_fifo.sv
// pixel_word_fifo: first-word-fall-through sync FIFO with occupancy count and drop flag
module pixel_word_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 34
) (
    input  logic                       clk,
    input  logic                       rst_gen,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       valid,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          full, push, pop;
    assign valid   = cnt != '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign pop     = rd_en && valid;
    assign push    = wr_en && (!full || pop);
    assign drop    = wr_en && !push;
    assign rd_data = valid ? mem[rp] : '0;
    assign count   = cnt;
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= push ? wp + 1'b1 : wp;
            rp  <= pop ? rp + 1'b1 : rp;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wp] <= wr_data;
endmodule

// File: rtl/pixel_packer.sv
// pixel_packer: packs grey shades as 24-bit RGB, 4 pixels into 3 AXI-Stream words, with frame flags and throttle
module pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int SHADE_W      = 8,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic               clk,
    input  logic               rst_gen,
    input  logic [SHADE_W-1:0] shade_in,
    input  logic               pixel_valid,
    pixel_packer_if.master     axis,
    output logic               stall_req,
    output logic               overflow,
    output logic               frame_done
);
    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [7:0]    s;
    pixel24_t      p, hold;
    logic [1:0]    phase;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof, last_x, last_y, push, drop;
    axis_word_t    w, head;
    logic [CW-1:0] count;
    assign s      = 8'(shade_in) << (8 - SHADE_W);
    assign p      = expand(s);
    assign last_x = x == XW'(H_RES - 1);
    assign last_y = y == YW'(V_RES - 1);
    assign push   = pixel_valid && phase != P0;
    assign w = '{
        tuser: phase == P1 && sof,
        tlast: phase == P3 && last_x,
        data:  phase == P1 ? {p[7:0], hold} : phase == P2 ? {p[15:0], hold[15:0]} : {p, hold[7:0]}
    };
    always_ff @(posedge clk or negedge rst_gen) begin
        if (!rst_gen) begin
            phase      <= P0;
            hold       <= '0;
            x          <= '0;
            y          <= '0;
            sof        <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            stall_req  <= 1'b0;
        end else begin
            frame_done <= pixel_valid && last_x && last_y;
            overflow   <= overflow | drop;
            stall_req  <= 32'(count) >= AFULL_THRESH;
            if (pixel_valid) begin
                phase <= phase + 2'd1;
                hold  <= phase == P0 ? p : phase == P1 ? {8'd0, p[23:8]} : {16'd0, p[23:16]};
                sof   <= phase == P0 ? (x == '0 && y == '0) : sof;
                x     <= last_x ? '0 : x + 1'b1;
                y     <= !last_x ? y : last_y ? '0 : y + 1'b1;
            end
        end
    end
    pixel_word_fifo #(.DEPTH(FIFO_DEPTH), .W(34)) u_fifo (
        .clk     (clk),
        .rst_gen (rst_gen),
        .wr_en   (push),
        .wr_data (w),
        .rd_en   (axis.out_tready),
        .rd_data (head),
        .valid   (axis.out_tvalid),
        .drop    (drop),
        .count   (count)
    );
    assign axis.out_tdata = head.data;
    assign axis.out_tuser = head.tuser;
    assign axis.out_tlast = head.tlast;
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed checks of packing, frame flags, FIFO stall/overflow and reset for pixel_packer
module tb_pixel_packer;
    logic       clk = 1'b0;
    logic       rst_gen = 1'b0;
    logic [7:0] shade_in = '0;
    logic       pixel_valid = 1'b0;
    logic       stall_req, overflow, frame_done;
    logic       rnd = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         fd_cnt = 0;
    logic [33:0] rx[$];
    logic [7:0]  sh[64];
    pixel_packer_if ifc();
    pixel_packer #(
        .SHADE_W(8), .H_RES(8), .V_RES(2), .FIFO_DEPTH(16), .AFULL_THRESH(12)
    ) dut (
        .clk         (clk),
        .rst_gen     (rst_gen),
        .shade_in    (shade_in),
        .pixel_valid (pixel_valid),
        .axis        (ifc),
        .stall_req   (stall_req),
        .overflow    (overflow),
        .frame_done  (frame_done)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (ifc.out_tvalid && ifc.out_tready) rx.push_back({ifc.out_tuser, ifc.out_tlast, ifc.out_tdata});
        if (frame_done) fd_cnt++;
    end
    always @(posedge clk) if (rnd) #1 ifc.out_tready = ($urandom_range(3) == 0);
    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic pix(input logic [7:0] v);
        shade_in = v;
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
    endtask
    task automatic do_reset();
        rst_gen = 1'b0;
        tick(2);
        rst_gen = 1'b1;
        tick();
        rx.delete();
        fd_cnt = 0;
    endtask
    task automatic wait_rx(input int n);
        int t = 0;
        while (rx.size() < n && t < 3000) begin
            tick();
            t++;
        end
        check("rx_count", rx.size(), n);
    endtask
    // Independent reference: 8-pixel lines give 6 words per line, 12 per frame
    function automatic logic [33:0] ref_word(input int k);
        int g = k / 3;
        int j = k % 3;
        logic [7:0] s0 = sh[4*g], s1 = sh[4*g+1], s2 = sh[4*g+2], s3 = sh[4*g+3];
        logic [31:0] d = j == 0 ? {s1, s0, s0, s0} : j == 1 ? {s2, s2, s1, s1} : {s3, s3, s3, s2};
        return {k % 12 == 0, k % 6 == 5, d};
    endfunction
    initial begin
        ifc.out_tready = 1'b0;
        tick(2);
        check("rst_tvalid", ifc.out_tvalid, 0);
        check("rst_tdata", ifc.out_tdata, 0);
        check("rst_tuser", ifc.out_tuser, 0);
        check("rst_tlast", ifc.out_tlast, 0);
        check("rst_stall", stall_req, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_done", frame_done, 0);
        rst_gen = 1'b1;
        tick();
        ifc.out_tready = 1'b1;
        rx.delete();
        pix(8'h11); pix(8'h22); pix(8'h33); pix(8'h44);
        wait_rx(3);
        tick(3);
        check("t1_size", rx.size(), 3);
        check("t1_w0", rx[0], {2'b10, 32'h22111111});
        check("t1_w1", rx[1], {2'b00, 32'h33332222});
        check("t1_w2", rx[2], {2'b00, 32'h44444433});
        pix(8'h01); pix(8'h02); pix(8'h03); pix(8'h04);
        wait_rx(6);
        check("t2_w0", rx[3], {2'b00, 32'h02010101});
        check("t2_w1", rx[4], {2'b00, 32'h03030202});
        check("t2_w2", rx[5], {2'b01, 32'h04040403});
        do_reset();
        ifc.out_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sh[i] = 8'(i * 9 + 5);
            pix(sh[i]);
        end
        wait_rx(15);
        tick(4);
        check("frame_size", rx.size(), 15);
        for (int k = 0; k < 15; k++) check($sformatf("frame_w%0d", k), rx[k], ref_word(k));
        check("frame_done_cnt", fd_cnt, 1);
        do_reset();
        ifc.out_tready = 1'b0;
        begin
            int cnt = 0;
            int old;
            for (int i = 0; i < 24; i++) begin
                sh[i] = 8'(i * 11 + 1);
                old = cnt;
                pix(sh[i]);
                if (i % 4 != 0 && cnt < 16) cnt++;
                check($sformatf("stall_p%0d", i), stall_req, old >= 12);
            end
        end
        check("stall_overflow", overflow, 1);
        tick(5);
        check("stall_hold", {ifc.out_tuser, ifc.out_tlast, ifc.out_tdata}, ref_word(0));
        ifc.out_tready = 1'b1;
        wait_rx(16);
        tick(5);
        check("stall_size", rx.size(), 16);
        for (int k = 0; k < 16; k++) check($sformatf("stall_w%0d", k), rx[k], ref_word(k));
        check("stall_empty", ifc.out_tvalid, 0);
        do_reset();
        rnd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            int t = 0;
            sh[i] = 8'(i * 13 + 7);
            while (stall_req && t < 500) begin
                tick();
                t++;
            end
            pix(sh[i]);
            tick(4);
        end
        wait_rx(24);
        rnd = 1'b0;
        ifc.out_tready = 1'b1;
        tick(3);
        check("rnd_size", rx.size(), 24);
        for (int k = 0; k < 24; k++) check($sformatf("rnd_w%0d", k), rx[k], ref_word(k));
        check("rnd_overflow", overflow, 0);
        check("rnd_frame_done_cnt", fd_cnt, 2);
        do_reset();
        ifc.out_tready = 1'b1;
        pix(8'hAA); pix(8'hBB);
        rst_gen = 1'b0;
        #1;
        check("mid_rst_tvalid", ifc.out_tvalid, 0);
        tick();
        rst_gen = 1'b1;
        tick();
        rx.delete();
        pix(8'h10); pix(8'h20); pix(8'h30); pix(8'h40);
        wait_rx(3);
        check("mid_rst_w0", rx[0], {2'b10, 32'h20101010});
        check("mid_rst_w1", rx[1], {2'b00, 32'h30302020});
        check("mid_rst_w2", rx[2], {2'b00, 32'h40404030});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
